sram_arbiter: RTL and testbench

- Shares the single off-chip 16-bit SRAM between two 32-bit requesters: instruction fetch (IF, read-only) and the MEM stage (read/write).
- Arbitrates between the two requesters and latches the winning request.
- Sequences each 32-bit access as two 16-bit SRAM phases, low half first.
- Generates per-requester freeze signals that stall the pipeline until the access completes.

---
 rtl/sram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a 16-bit async SRAM; each 32-bit access is two halfword phases.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of MEM-over-IF priority.
module sram_arbiter #(
    parameter int PHASE_CYC = 2,
    parameter int ADDR_W    = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [17:0]       SRAM_ADDR,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(PHASE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [15:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        if_act, mem_act, grant_mem;
    logic        busy, dq_oe;
    logic [15:0] dq_out;
    logic        unused_addr_lsb;

    assign if_act  = if_req;
    assign mem_act = mem_r_en | mem_w_en;
    assign unused_addr_lsb = ^{if_addr[1:0], mem_addr[1:0]};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // rr_q remembers the last grant; on contention the other side wins
    logic rr_q, rr_d;
    assign grant_mem = mem_act & (~if_act | ~rr_q);
`else
    assign grant_mem = mem_act;
`endif

    assign busy   = (state_q == LO) || (state_q == HI);
    assign dq_oe  = busy && wr_q;
    assign dq_out = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = (state_q == DONE) && !owner_q;
    assign mem_ready  = (state_q == DONE) && owner_q;
    assign if_freeze  = if_req & ~if_ready;
    assign mem_freeze = mem_act & ~mem_ready;

    // Pin drive depends only on flops so the DQ read path stays loop-free
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        if (busy) begin
            SRAM_CE_N = 1'b0;
            SRAM_ADDR = {1'b0, word_q, state_q == HI};
            if (wr_q) begin
                SRAM_WE_N = (cnt_q == 4'd0);
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (if_act || mem_act) begin
                    owner_d = grant_mem;
                    wr_d    = grant_mem & mem_w_en;
                    word_d  = grant_mem ? mem_addr[17:2] : if_addr[17:2];
                    wdata_d = mem_wdata;
                    cnt_d   = '0;
                    state_d = LO;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    rr_d    = grant_mem;
`endif
                end
            end
            LO, HI: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (state_q == LO) begin
                        state_d = HI;
                        if (!wr_q) lo_d = SRAM_DQ;
                    end else begin
                        state_d = DONE;
                        if (!wr_q && owner_q) mem_rdata_d = {SRAM_DQ, lo_q};
                        if (!wr_q && !owner_q) if_rdata_d = {SRAM_DQ, lo_q};
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: word-level memory model, arbitration rule and
// latency formula predict each completion; an SRAM pin model backs the DUT.
module tb_sram_arbiter;

    localparam int P   = 2;
    localparam int AW  = 18;
    localparam int LAT = 2 * P + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, mem_r_en, mem_w_en;
    logic [AW-1:0] if_addr, mem_addr;
    logic [31:0]   mem_wdata, if_rdata, mem_rdata;
    logic          if_ready, if_freeze, mem_ready, mem_freeze;
    wire  [15:0]   SRAM_DQ;
    logic [17:0]   SRAM_ADDR;
    logic          SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

    sram_arbiter #(.PHASE_CYC(P), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_freeze(if_freeze),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_freeze(mem_freeze),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM pin model
    logic [15:0] sram [0:262143];
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR] : 16'hzzzz;

    typedef struct { logic [17:0] a; logic [15:0] d; } wr_t;
    wr_t wlog[$];
    int  we_low = 0;
    int  oe_low = 0;

    always @(negedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            sram[SRAM_ADDR] = SRAM_DQ;
            wlog.push_back('{a: SRAM_ADDR, d: SRAM_DQ});
            we_low++;
        end
        if (!SRAM_CE_N && !SRAM_OE_N) oe_low++;
    end

    // Reference model and scoreboard
    typedef struct { bit mem; bit rd; logic [31:0] data; int due; } exp_t;
    exp_t        q[$];
    logic [31:0] model [0:63];
    bit          rr_last_mem = 1'b0;
    int          vec = 0;
    int          bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit   ei, em;
        exp_t e;
        ei = 1'b0;
        em = 1'b0;
        if (!rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.mem) em = 1'b1;
                else ei = 1'b1;
                if (e.rd && e.mem) check("mem_rdata", mem_rdata, e.data);
                if (e.rd && !e.mem) check("if_rdata", if_rdata, e.data);
            end
            check("if_ready", {31'd0, if_ready}, {31'd0, ei});
            check("mem_ready", {31'd0, mem_ready}, {31'd0, em});
            if (if_req) check("if_freeze", {31'd0, if_freeze}, {31'd0, !ei});
            if (mem_r_en || mem_w_en)
                check("mem_freeze", {31'd0, mem_freeze}, {31'd0, !em});
            if (!SRAM_WE_N) check("oe_high_during_we", {31'd0, SRAM_OE_N}, 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
        if_addr   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    // kind: 0 IF only, 1 MEM only, 2 both; mop: 0 read, 1 write, 2 both enables
    task automatic run_round(int kind, int mop, bit withdraw, int iw, int mw,
                             logic [31:0] wd, logic [1:0] ilsb, logic [1:0] mlsb);
        int c;
        bit win_mem;
        int win_due, lose_due, last_due;
        c = cyc;
        if (kind == 2) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            win_mem = !rr_last_mem;
`else
            win_mem = 1'b1;
`endif
        end else begin
            win_mem = (kind == 1);
        end
        rr_last_mem = (kind == 2) ? !win_mem : win_mem;
        if_req    = (kind != 1);
        if_addr   = AW'(iw * 4) | AW'(ilsb);
        mem_r_en  = (kind != 0) && (mop == 0 || mop == 2);
        mem_w_en  = (kind != 0) && (mop != 0);
        mem_addr  = AW'(mw * 4) | AW'(mlsb);
        mem_wdata = wd;
        win_due   = c + LAT;
        lose_due  = c + LAT + (LAT + 1);
        for (int s = 0; s < 2; s++) begin
            bit sm;
            int d;
            if (s == 1 && kind != 2) break;
            sm = (s == 0) ? win_mem : !win_mem;
            d  = (s == 0) ? win_due : lose_due;
            if (sm && mop != 0) begin
                model[mw] = wd;
                q.push_back('{mem: 1'b1, rd: 1'b0, data: 32'h0, due: d});
            end else if (sm) begin
                q.push_back('{mem: 1'b1, rd: 1'b1, data: model[mw], due: d});
            end else begin
                q.push_back('{mem: 1'b0, rd: 1'b1, data: model[iw], due: d});
            end
        end
        last_due = (kind == 2) ? lose_due : win_due;
        for (int k = 1; k <= last_due + 1 - c; k++) begin
            step();
            if (k == 1) begin
                if (win_mem) begin
                    mem_addr  = AW'($urandom);
                    mem_wdata = $urandom;
                end else begin
                    if_addr = AW'($urandom);
                end
            end
            if ((k == 1 && withdraw) || cyc == win_due + 1) begin
                if (win_mem) begin
                    mem_r_en = 1'b0;
                    mem_w_en = 1'b0;
                end else begin
                    if_req = 1'b0;
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        int c;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            model[i]     = w;
            sram[2*i]    = w[15:0];
            sram[2*i+1]  = w[31:16];
        end
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        check("rst_addr", {14'd0, SRAM_ADDR}, 32'h0);
        check("rst_freeze", {30'd0, if_freeze, mem_freeze}, 32'h0);

        // Reset in the second cycle of a MEM write
        step();
        c = cyc;
        mem_w_en  = 1'b1;
        mem_addr  = 18'h00040;
        mem_wdata = $urandom;
        step();
        @(negedge clk);
        check("abort_ce_active", {31'd0, SRAM_CE_N}, 32'd0);
        #1;
        rst = 1'b1;
        mem_w_en = 1'b0;
        step();
        rst = 1'b0;
        check("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("abort_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        check("abort_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        check("abort_cycle", cyc, c + 2);
        rr_last_mem = 1'b0;
        repeat (8) step();

        // Directed write of 0xDEADBEEF to byte address 0x10
        wlog.delete();
        we_low = 0;
        run_round(1, 1, 1'b0, 0, 4, 32'hDEADBEEF, 2'd0, 2'd0);
        check("wr_count", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            check("wr0_addr", {14'd0, wlog[0].a}, 32'h8);
            check("wr0_data", {16'd0, wlog[0].d}, 32'hBEEF);
            check("wr1_addr", {14'd0, wlog[1].a}, 32'h9);
            check("wr1_data", {16'd0, wlog[1].d}, 32'hDEAD);
        end
        check("we_low_cycles", we_low, 32'd2);

        // IF read back of the same word
        oe_low = 0;
        run_round(0, 0, 1'b0, 4, 0, 32'h0, 2'd0, 2'd0);
        check("oe_low_cycles", oe_low, 32'(2 * P));

        // Simultaneous IF and MEM reads
        run_round(2, 0, 1'b0, 4, 7, 32'h0, 2'd0, 2'd0);

        // Both MEM enables behave as a write
        wlog.delete();
        oe_low = 0;
        run_round(1, 2, 1'b0, 0, 9, 32'h1234_5678, 2'd1, 2'd2);
        check("both_en_wr_count", wlog.size(), 32'd2);
        check("both_en_oe_low", oe_low, 32'd0);

        // Write request dropped after one cycle
        run_round(1, 1, 1'b1, 0, 9, 32'hCAFE_F00D, 2'd0, 2'd3);
        run_round(1, 0, 1'b0, 0, 9, 32'h0, 2'd0, 2'd0);

        for (int r = 0; r < 150; r++) begin
            int  kind, mop;
            bit  wd;
            kind = $urandom_range(0, 2);
            mop  = $urandom_range(0, 2);
            wd   = (kind != 2) && ($urandom_range(0, 3) == 0);
            run_round(kind, mop, wd, $urandom_range(0, 63), $urandom_range(0, 63),
                      $urandom, 2'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end

        repeat (4) step();
        check("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
